// File: rtl/roce_latency_stats_if.sv
// Latency sample input and window result output of one latency statistics channel.
interface roce_latency_stats_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int WINDOW_LOG2 = 4,
  parameter int SUM_WIDTH   = DATA_WIDTH + WINDOW_LOG2
);
  logic                  s_lat_valid;
  logic [DATA_WIDTH-1:0] s_lat_data;
  logic                  m_stat_valid;
  logic                  m_stat_ready;
  logic [DATA_WIDTH-1:0] m_stat_min;
  logic [DATA_WIDTH-1:0] m_stat_max;
  logic [SUM_WIDTH-1:0]  m_stat_sum;
  logic [DATA_WIDTH-1:0] m_stat_mean;
  logic [31:0]           m_stat_window_idx;

  // Statistics block: consumes samples, produces window results.
  modport master (
    input  s_lat_valid, s_lat_data, m_stat_ready,
    output m_stat_valid, m_stat_min, m_stat_max, m_stat_sum, m_stat_mean, m_stat_window_idx
  );

  // Environment: produces samples, consumes window results.
  modport slave (
    output s_lat_valid, s_lat_data, m_stat_ready,
    input  m_stat_valid, m_stat_min, m_stat_max, m_stat_sum, m_stat_mean, m_stat_window_idx
  );
endinterface

// File: rtl/roce_latency_stats.sv
// Aggregates latency samples over windows of 2^WINDOW_LOG2 samples and publishes
// min/max/sum/mean per window on a valid/ready result port.
module roce_latency_stats #(
  parameter int DATA_WIDTH  = 64,
  parameter int WINDOW_LOG2 = 4,
  parameter int SUM_WIDTH   = DATA_WIDTH + WINDOW_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  roce_latency_stats_if.master bus,
  output logic [31:0]          sample_count,
  output logic                 overrun
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                  state_q, state_d;
  logic                    start_d_q;
  logic [DATA_WIDTH-1:0]   acc_min_q, acc_min_d;
  logic [DATA_WIDTH-1:0]   acc_max_q, acc_max_d;
  logic [SUM_WIDTH-1:0]    acc_sum_q, acc_sum_d;
  logic [WINDOW_LOG2-1:0]  acc_cnt_q, acc_cnt_d;
  logic [31:0]             win_idx_q, win_idx_d;
  logic [DATA_WIDTH-1:0]   res_min_q, res_min_d;
  logic [DATA_WIDTH-1:0]   res_max_q, res_max_d;
  logic [SUM_WIDTH-1:0]    res_sum_q, res_sum_d;
  logic [31:0]             res_idx_q, res_idx_d;
  logic [31:0]             sample_count_q, sample_count_d;
  logic                    overrun_q, overrun_d;

  logic                    clear;
  logic                    handshake;
  logic                    close;
  logic [DATA_WIDTH-1:0]   smp_min;
  logic [DATA_WIDTH-1:0]   smp_max;
  logic [SUM_WIDTH-1:0]    smp_sum;

  // Next-state logic for accumulators, result registers and the result-side FSM.
  always_comb begin
    clear     = start_i & ~start_d_q;
    handshake = (state_q == ST_FULL) & bus.m_stat_ready;
    close     = bus.s_lat_valid & (acc_cnt_q == '1);
    smp_min   = (bus.s_lat_data < acc_min_q) ? bus.s_lat_data : acc_min_q;
    smp_max   = (bus.s_lat_data > acc_max_q) ? bus.s_lat_data : acc_max_q;
    smp_sum   = acc_sum_q + SUM_WIDTH'(bus.s_lat_data);

    state_d        = state_q;
    acc_min_d      = acc_min_q;
    acc_max_d      = acc_max_q;
    acc_sum_d      = acc_sum_q;
    acc_cnt_d      = acc_cnt_q;
    win_idx_d      = win_idx_q;
    res_min_d      = res_min_q;
    res_max_d      = res_max_q;
    res_sum_d      = res_sum_q;
    res_idx_d      = res_idx_q;
    sample_count_d = sample_count_q;
    overrun_d      = overrun_q;

    if (clear) begin
      // Restart discards any partial window and the pending result.
      state_d        = ST_EMPTY;
      acc_min_d      = '1;
      acc_max_d      = '0;
      acc_sum_d      = '0;
      acc_cnt_d      = '0;
      win_idx_d      = '0;
      res_min_d      = '0;
      res_max_d      = '0;
      res_sum_d      = '0;
      res_idx_d      = '0;
      sample_count_d = '0;
      overrun_d      = 1'b0;
    end else begin
      if (bus.s_lat_valid) begin
        if (sample_count_q != 32'hFFFF_FFFF) begin
          sample_count_d = sample_count_q + 32'd1;
        end
        if (close) begin
          // Publish the window including this sample; accumulators restart
          // immediately so the next sample opens a new window.
          res_min_d = smp_min;
          res_max_d = smp_max;
          res_sum_d = smp_sum;
          res_idx_d = win_idx_q;
          acc_min_d = '1;
          acc_max_d = '0;
          acc_sum_d = '0;
          acc_cnt_d = '0;
          win_idx_d = win_idx_q + 32'd1;
          state_d   = ST_FULL;
          if ((state_q == ST_FULL) && !handshake) begin
            overrun_d = 1'b1;
          end
        end else begin
          acc_min_d = smp_min;
          acc_max_d = smp_max;
          acc_sum_d = smp_sum;
          acc_cnt_d = acc_cnt_q + WINDOW_LOG2'(1);
        end
      end
      if (handshake && !close) begin
        state_d = ST_EMPTY;
      end
    end
  end

  // State registers; start_d tracks start_i even during reset.
  always_ff @(posedge clk) begin
    start_d_q <= start_i;
    if (!rst) begin
      state_q        <= ST_EMPTY;
      acc_min_q      <= '1;
      acc_max_q      <= '0;
      acc_sum_q      <= '0;
      acc_cnt_q      <= '0;
      win_idx_q      <= '0;
      res_min_q      <= '0;
      res_max_q      <= '0;
      res_sum_q      <= '0;
      res_idx_q      <= '0;
      sample_count_q <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_min_q      <= acc_min_d;
      acc_max_q      <= acc_max_d;
      acc_sum_q      <= acc_sum_d;
      acc_cnt_q      <= acc_cnt_d;
      win_idx_q      <= win_idx_d;
      res_min_q      <= res_min_d;
      res_max_q      <= res_max_d;
      res_sum_q      <= res_sum_d;
      res_idx_q      <= res_idx_d;
      sample_count_q <= sample_count_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.m_stat_valid      = (state_q == ST_FULL);
  assign bus.m_stat_min        = res_min_q;
  assign bus.m_stat_max        = res_max_q;
  assign bus.m_stat_sum        = res_sum_q;
  assign bus.m_stat_mean       = DATA_WIDTH'(res_sum_q >> WINDOW_LOG2);
  assign bus.m_stat_window_idx = res_idx_q;
  assign sample_count          = sample_count_q;
  assign overrun               = overrun_q;

endmodule

// File: tb/tb_roce_latency_stats.sv
// Self-checking bench for roce_latency_stats (DATA_WIDTH=16, WINDOW_LOG2=2).
module tb_roce_latency_stats;
  localparam int DW = 16;
  localparam int WL = 2;
  localparam int SW = DW + WL;
  localparam int WIN = 1 << WL;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] sample_count;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  roce_latency_stats_if #(.DATA_WIDTH(DW), .WINDOW_LOG2(WL)) bus ();

  roce_latency_stats #(.DATA_WIDTH(DW), .WINDOW_LOG2(WL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .bus          (bus),
    .sample_count (sample_count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: the open window is kept as a list of samples and
  // summarised only when it holds WIN entries.
  bit          m_valid;
  logic [DW-1:0] m_min, m_max;
  logic [SW-1:0] m_sum;
  logic [31:0] m_widx, m_next, m_cnt;
  bit          m_ovr;
  bit          m_start_d;
  logic [DW-1:0] win[$];

  task automatic model_step(input bit r, input bit s, input bit v, input logic [DW-1:0] d, input bit rdy);
    bit edge_s, hs;
    logic [DW-1:0] mn, mx;
    logic [SW-1:0] sm;
    edge_s = s && !m_start_d;
    m_start_d = s;
    if (!r || edge_s) begin
      m_valid = 0; m_min = 0; m_max = 0; m_sum = 0; m_widx = 0;
      m_next = 0; m_cnt = 0; m_ovr = 0;
      win.delete();
    end else begin
      hs = m_valid && rdy;
      if (v) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        win.push_back(d);
      end
      if (win.size() == WIN) begin
        mn = '1; mx = '0; sm = '0;
        foreach (win[i]) begin
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
          sm = sm + SW'(win[i]);
        end
        if (m_valid && !hs) m_ovr = 1;
        m_valid = 1; m_min = mn; m_max = mx; m_sum = sm;
        m_widx = m_next; m_next = m_next + 1;
        win.delete();
      end else if (hs) begin
        m_valid = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit r, input bit s, input bit v, input logic [DW-1:0] d, input bit rdy);
    rst = r; start_i = s;
    bus.s_lat_valid = v; bus.s_lat_data = d; bus.m_stat_ready = rdy;
    model_step(r, s, v, d, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 16'd5, 0);
    n_cmp++; if (bus.m_stat_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0d exp 0", bus.m_stat_valid); end
    n_cmp++; if (bus.m_stat_min !== 16'd0 || bus.m_stat_max !== 16'd0) begin n_bad++; $display("FAIL reset_minmax got %0d/%0d exp 0/0", bus.m_stat_min, bus.m_stat_max); end
    n_cmp++; if (bus.m_stat_sum !== 18'd0 || bus.m_stat_mean !== 16'd0) begin n_bad++; $display("FAIL reset_summean got %0d/%0d exp 0/0", bus.m_stat_sum, bus.m_stat_mean); end
    n_cmp++; if (sample_count !== 32'd0 || overrun !== 1'b0 || bus.m_stat_window_idx !== 32'd0) begin n_bad++; $display("FAIL reset_misc got cnt=%0d ovr=%0d idx=%0d exp 0", sample_count, overrun, bus.m_stat_window_idx); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [DW-1:0] s [4];
    s = '{16'd10, 16'd30, 16'd20, 16'd40};
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.m_stat_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %0d exp 0 at %0d", bus.m_stat_valid, i); end
      cycle(1, 0, 1, s[i], 1);
    end
    n_cmp++; if (bus.m_stat_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0d exp 1", bus.m_stat_valid); end
    n_cmp++; if (bus.m_stat_min !== 16'd10 || bus.m_stat_max !== 16'd40) begin n_bad++; $display("FAIL basic_minmax got %0d/%0d exp 10/40", bus.m_stat_min, bus.m_stat_max); end
    n_cmp++; if (bus.m_stat_sum !== 18'd100 || bus.m_stat_mean !== 16'd25) begin n_bad++; $display("FAIL basic_summean got %0d/%0d exp 100/25", bus.m_stat_sum, bus.m_stat_mean); end
    n_cmp++; if (bus.m_stat_window_idx !== 32'd0 || sample_count !== 32'd4) begin n_bad++; $display("FAIL basic_idxcnt got %0d/%0d exp 0/4", bus.m_stat_window_idx, sample_count); end
    cycle(1, 0, 0, 0, 1);
    n_cmp++; if (bus.m_stat_valid !== 1'b0) begin n_bad++; $display("FAIL basic_handshake_valid got %0d exp 0", bus.m_stat_valid); end
    $display("test_basic window min=10 max=40 sum=100 mean=25");
  endtask

  task automatic test_all_ones();
    logic [DW-1:0] s [4];
    restart();
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 16'hFFFF, 1);
    n_cmp++; if (bus.m_stat_sum !== 18'h3FFFC || bus.m_stat_mean !== 16'hFFFF) begin n_bad++; $display("FAIL ones_summean got %h/%h exp 3fffc/ffff", bus.m_stat_sum, bus.m_stat_mean); end
    n_cmp++; if (bus.m_stat_min !== 16'hFFFF || bus.m_stat_max !== 16'hFFFF) begin n_bad++; $display("FAIL ones_minmax got %h/%h exp ffff/ffff", bus.m_stat_min, bus.m_stat_max); end
    s = '{16'd1, 16'd2, 16'd3, 16'd4};
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, s[i], 1);
    n_cmp++; if (bus.m_stat_window_idx !== 32'd1 || bus.m_stat_sum !== 18'd10) begin n_bad++; $display("FAIL ones_second_idxsum got %0d/%0d exp 1/10", bus.m_stat_window_idx, bus.m_stat_sum); end
    n_cmp++; if (bus.m_stat_mean !== 16'd2 || bus.m_stat_min !== 16'd1 || bus.m_stat_max !== 16'd4) begin n_bad++; $display("FAIL ones_second_stats got mean=%0d min=%0d max=%0d exp 2/1/4", bus.m_stat_mean, bus.m_stat_min, bus.m_stat_max); end
    $display("test_all_ones windows 0xFFFF and 1..4");
  endtask

  task automatic test_overrun();
    restart();
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 16'd1, 0);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first_window got %0d exp 0", overrun); end
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 16'd5, 0);
    n_cmp++; if (bus.m_stat_min !== 16'd5 || bus.m_stat_window_idx !== 32'd1) begin n_bad++; $display("FAIL ovr_result got min=%0d idx=%0d exp 5/1", bus.m_stat_min, bus.m_stat_window_idx); end
    n_cmp++; if (overrun !== 1'b1 || bus.m_stat_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got ovr=%0d valid=%0d exp 1/1", overrun, bus.m_stat_valid); end
    cycle(1, 0, 0, 0, 1);
    n_cmp++; if (bus.m_stat_valid !== 1'b0 || overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_after_accept got valid=%0d ovr=%0d exp 0/1", bus.m_stat_valid, overrun); end
    $display("test_overrun window idx=1 overwritten");
  endtask

  task automatic test_partial_restart();
    cycle(1, 0, 1, 16'd7, 1);
    cycle(1, 0, 1, 16'd9, 1);
    restart();
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 16'd3, 1);
    n_cmp++; if (bus.m_stat_sum !== 18'd12 || bus.m_stat_window_idx !== 32'd0) begin n_bad++; $display("FAIL partial_sumidx got %0d/%0d exp 12/0", bus.m_stat_sum, bus.m_stat_window_idx); end
    n_cmp++; if (sample_count !== 32'd4 || overrun !== 1'b0) begin n_bad++; $display("FAIL partial_cntovr got %0d/%0d exp 4/0", sample_count, overrun); end
    $display("test_partial_restart window sum=12");
  endtask

  task automatic test_start_and_rst();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 1, 16'd50, 1);
    n_cmp++; if (sample_count !== 32'd0) begin n_bad++; $display("FAIL start_coincident_cnt got %0d exp 0", sample_count); end
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 16'(i + 2), 0);
    n_cmp++; if (bus.m_stat_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got %0d exp 1", bus.m_stat_valid); end
    cycle(0, 1, 1, 16'd99, 1);
    n_cmp++; if (bus.m_stat_valid !== 1'b0 || sample_count !== 32'd0 || bus.m_stat_sum !== 18'd0 || bus.m_stat_min !== 16'd0) begin n_bad++; $display("FAIL rst_mid got valid=%0d cnt=%0d sum=%0d min=%0d exp 0", bus.m_stat_valid, sample_count, bus.m_stat_sum, bus.m_stat_min); end
    cycle(1, 1, 1, 16'd77, 0);
    n_cmp++; if (sample_count !== 32'd1) begin n_bad++; $display("FAIL start_held_through_rst_cnt got %0d exp 1", sample_count); end
    cycle(1, 0, 1, 16'd1, 0);
    cycle(1, 0, 1, 16'd1, 0);
    cycle(1, 0, 1, 16'd1, 0);
    n_cmp++; if (bus.m_stat_sum !== 18'd80 || bus.m_stat_window_idx !== 32'd0 || bus.m_stat_min !== 16'd1) begin n_bad++; $display("FAIL rst_next_window got sum=%0d idx=%0d min=%0d exp 80/0/1", bus.m_stat_sum, bus.m_stat_window_idx, bus.m_stat_min); end
    $display("test_start_and_rst done");
  endtask

  task automatic test_back_to_back();
    restart();
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 16'd8, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, 16'(20 + i), (i == 3));
      n_cmp++; if (bus.m_stat_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %0d exp 1 at %0d", bus.m_stat_valid, i); end
    end
    n_cmp++; if (bus.m_stat_sum !== 18'd86 || bus.m_stat_min !== 16'd20 || bus.m_stat_window_idx !== 32'd1) begin n_bad++; $display("FAIL b2b_result got sum=%0d min=%0d idx=%0d exp 86/20/1", bus.m_stat_sum, bus.m_stat_min, bus.m_stat_window_idx); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %0d exp 0", overrun); end
    $display("test_back_to_back window idx=1 sum=86");
  endtask

  task automatic test_random();
    bit r, s, v, rdy;
    logic [DW-1:0] d;
    restart();
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 99) != 0);
      s   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       d = '0;
        1:       d = '1;
        default: d = DW'($urandom);
      endcase
      if (bus.m_stat_valid && rdy)
        $display("rand accept idx=%0d min=%0d max=%0d sum=%0d", bus.m_stat_window_idx, bus.m_stat_min, bus.m_stat_max, bus.m_stat_sum);
      cycle(r, s, v, d, rdy);
      n_cmp++; if (bus.m_stat_valid !== m_valid) begin n_bad++; $display("FAIL rand_valid c=%0d got %0d exp %0d", c, bus.m_stat_valid, m_valid); end
      n_cmp++; if (bus.m_stat_min !== m_min || bus.m_stat_max !== m_max) begin n_bad++; $display("FAIL rand_minmax c=%0d got %0d/%0d exp %0d/%0d", c, bus.m_stat_min, bus.m_stat_max, m_min, m_max); end
      n_cmp++; if (bus.m_stat_sum !== m_sum || bus.m_stat_mean !== DW'(m_sum / WIN)) begin n_bad++; $display("FAIL rand_summean c=%0d got %0d/%0d exp %0d/%0d", c, bus.m_stat_sum, bus.m_stat_mean, m_sum, m_sum / WIN); end
      n_cmp++; if (bus.m_stat_window_idx !== m_widx || sample_count !== m_cnt || overrun !== m_ovr) begin n_bad++; $display("FAIL rand_misc c=%0d got idx=%0d cnt=%0d ovr=%0d exp %0d/%0d/%0d", c, bus.m_stat_window_idx, sample_count, overrun, m_widx, m_cnt, m_ovr); end
    end
    $display("test_random 600 cycles done");
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0;
    bus.s_lat_valid = 1'b0; bus.s_lat_data = '0; bus.m_stat_ready = 1'b0;
    test_reset();
    test_basic();
    test_all_ones();
    test_overrun();
    test_partial_restart();
    test_start_and_rst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
